// File: rtl/svga_timing_pkg.sv
// Display timing constants shared by the sync generator and its users.
// Holds the 800x600@72 and 640x480@60 modes plus the frame-total helpers.
package svga_timing_pkg;

    localparam int X_W = 11;
    localparam int Y_W = 10;

    // 800x600 @72 Hz, 50 MHz pixel rate from a 100 MHz clock
    localparam int SVGA_CLK_DIV = 2;
    localparam int SVGA_H_DISP  = 800;
    localparam int SVGA_H_FP    = 56;
    localparam int SVGA_H_SYNC  = 120;
    localparam int SVGA_H_BP    = 64;
    localparam int SVGA_V_DISP  = 600;
    localparam int SVGA_V_FP    = 37;
    localparam int SVGA_V_SYNC  = 6;
    localparam int SVGA_V_BP    = 23;
    localparam bit SVGA_H_POL   = 1'b1;
    localparam bit SVGA_V_POL   = 1'b1;

    // 640x480 @60 Hz, 25 MHz pixel rate from a 100 MHz clock
    localparam int VGA_CLK_DIV  = 4;
    localparam int VGA_H_DISP   = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_DISP   = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam bit VGA_H_POL    = 1'b0;
    localparam bit VGA_V_POL    = 1'b0;

    function automatic int h_total(input int disp, input int fp, input int sync, input int bp);
        return disp + fp + sync + bp;
    endfunction

    function automatic int v_total(input int disp, input int fp, input int sync, input int bp);
        return disp + fp + sync + bp;
    endfunction

endpackage

// File: rtl/svga_sync_gen_pixel_tick_gen.sv
// Pixel-rate enable: one clk-wide pulse every CLK_DIV system clocks.
// The pulse is registered so it is low during reset even when CLK_DIV is 1.
module pixel_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_reg;
    logic [DIV_W-1:0] div_cnt_next;
    logic             p_tick_reg;

    always_comb begin
        div_cnt_next = (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + DIV_W'(1);
    end

    // Loading the decode of the next count gives the same waveform as
    // decoding div_cnt_reg, without a path from reset to p_tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_reg <= '0;
            p_tick_reg  <= 1'b0;
        end else begin
            div_cnt_reg <= div_cnt_next;
            p_tick_reg  <= (div_cnt_next == DIV_LAST);
        end
    end

    assign p_tick = p_tick_reg;

endmodule

// File: rtl/svga_sync_gen.sv
// Horizontal/vertical timing core: pixel counters, registered syncs and
// visible-area flag, plus line/frame wrap pulses for the pixel generator.
module svga_sync_gen
    import svga_timing_pkg::*;
#(
    parameter int CLK_DIV = SVGA_CLK_DIV,
    parameter int H_DISP  = SVGA_H_DISP,
    parameter int H_FP    = SVGA_H_FP,
    parameter int H_SYNC  = SVGA_H_SYNC,
    parameter int H_BP    = SVGA_H_BP,
    parameter int V_DISP  = SVGA_V_DISP,
    parameter int V_FP    = SVGA_V_FP,
    parameter int V_SYNC  = SVGA_V_SYNC,
    parameter int V_BP    = SVGA_V_BP,
    parameter bit H_POL   = SVGA_H_POL,
    parameter bit V_POL   = SVGA_V_POL
) (
    input  logic           clk,
    input  logic           reset,
    output logic           p_tick,
    output logic           hsync,
    output logic           vsync,
    output logic           video_on,
    output logic [X_W-1:0] pixel_x,
    output logic [Y_W-1:0] pixel_y,
    output logic           line_end,
    output logic           frame_start
);

    localparam int H_TOTAL = h_total(H_DISP, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_DISP, V_FP, V_SYNC, V_BP);

    localparam logic [X_W-1:0] X_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0] X_VIS    = X_W'(H_DISP);
    localparam logic [X_W-1:0] HS_START = X_W'(H_DISP + H_FP);
    localparam logic [X_W-1:0] HS_STOP  = X_W'(H_DISP + H_FP + H_SYNC);
    localparam logic [Y_W-1:0] Y_LAST   = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0] Y_VIS    = Y_W'(V_DISP);
    localparam logic [Y_W-1:0] VS_START = Y_W'(V_DISP + V_FP);
    localparam logic [Y_W-1:0] VS_STOP  = Y_W'(V_DISP + V_FP + V_SYNC);

    logic [X_W-1:0] pixel_x_reg;
    logic [X_W-1:0] pixel_x_next;
    logic [Y_W-1:0] pixel_y_reg;
    logic [Y_W-1:0] pixel_y_next;
    logic           hsync_reg;
    logic           hsync_next;
    logic           vsync_reg;
    logic           vsync_next;
    logic           video_on_reg;
    logic           video_on_next;
    logic           x_wrap;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .p_tick (p_tick)
    );

    assign x_wrap = p_tick && (pixel_x_reg == X_LAST);

    always_comb begin
        pixel_x_next = pixel_x_reg;
        pixel_y_next = pixel_y_reg;
        if (p_tick) begin
            if (pixel_x_reg == X_LAST) begin
                pixel_x_next = '0;
                pixel_y_next = (pixel_y_reg == Y_LAST) ? '0 : pixel_y_reg + Y_W'(1);
            end else begin
                pixel_x_next = pixel_x_reg + X_W'(1);
            end
        end
    end

    // Decoding the next-state counters keeps the registered syncs in
    // phase with pixel_x/pixel_y instead of one pixel late.
    always_comb begin
        hsync_next    = (pixel_x_next >= HS_START && pixel_x_next < HS_STOP) ? H_POL : ~H_POL;
        vsync_next    = (pixel_y_next >= VS_START && pixel_y_next < VS_STOP) ? V_POL : ~V_POL;
        video_on_next = (pixel_x_next < X_VIS) && (pixel_y_next < Y_VIS);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_x_reg  <= '0;
            pixel_y_reg  <= '0;
            hsync_reg    <= ~H_POL;
            vsync_reg    <= ~V_POL;
            video_on_reg <= 1'b0;
        end else begin
            pixel_x_reg  <= pixel_x_next;
            pixel_y_reg  <= pixel_y_next;
            hsync_reg    <= hsync_next;
            vsync_reg    <= vsync_next;
            video_on_reg <= video_on_next;
        end
    end

    assign pixel_x     = pixel_x_reg;
    assign pixel_y     = pixel_y_reg;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign video_on    = video_on_reg;
    assign line_end    = x_wrap;
    assign frame_start = x_wrap && (pixel_y_reg == Y_LAST);

endmodule

// File: doc/svga_sync_gen.md
Name: svga_sync_gen

Overview:
- Timing core for the Ping_Pong_v2 display path. It sits directly upstream of the pixel/RGB generator.
- Divides the 100 MHz system clock into a pixel-enable tick.
- Runs the horizontal and vertical pixel counters.
- Produces registered hsync/vsync, video_on and pixel coordinates for the pixel generator's rgb logic.
- Defaults target SVGA 800x600 @72 Hz with a 50 MHz pixel rate; parameters also allow VGA 640x480.

Parameters:
- CLK_DIV, 2: system clocks per pixel tick (≥1).
- H_DISP, 800: visible pixels per line.
- H_FP, 56: horizontal front porch, in pixels.
- H_SYNC, 120: hsync pulse width, in pixels.
- H_BP, 64: horizontal back porch, in pixels.
- V_DISP, 600: visible lines.
- V_FP, 37: vertical front porch, in lines.
- V_SYNC, 6: vsync pulse width, in lines.
- V_BP, 23: vertical back porch, in lines.
- H_POL, 1: hsync active level (1 = active-high).
- V_POL, 1: vsync active level.

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high reset
- p_tick  out  1  pixel enable, one clk wide every CLK_DIV clks
- hsync  out  1  horizontal sync, registered
- vsync  out  1  vertical sync, registered
- video_on  out  1  high while in the visible area, registered
- pixel_x  out  11  current horizontal count, 0..H_TOTAL-1
- pixel_y  out  10  current vertical count, 0..V_TOTAL-1
- line_end  out  1  one-clk pulse on the tick where pixel_x wraps to 0
- frame_start  out  1  one-clk pulse on the tick where (x,y) wraps to (0,0)

Behaviour:
- Derived totals: H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP = 1040; V_TOTAL = V_DISP+V_FP+V_SYNC+V_BP = 666.
- One clock domain (clk); reset is synchronous and active-high. Reset has priority over every other event.
- Reset values:
  - div_cnt = 0, pixel_x = 0, pixel_y = 0.
  - p_tick = 0, line_end = 0, frame_start = 0, video_on = 0.
  - hsync = ~H_POL and vsync = ~V_POL (inactive).
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - p_tick = (div_cnt == CLK_DIV-1), decoded from the register.
  - The first p_tick occurs on the CLK_DIV-th clk after reset deasserts.
  - With CLK_DIV = 1, p_tick is held constantly high (out of reset).
- Counters advance only on clks where p_tick is high:
  - pixel_x increments and wraps from H_TOTAL-1 to 0.
  - pixel_y increments only when pixel_x wraps, and wraps from V_TOTAL-1 to 0.
- Output registers are loaded with decodes of the next-state counter values, so they align with pixel_x/pixel_y with zero skew:
  - hsync = H_POL when H_DISP+H_FP ≤ x < H_DISP+H_FP+H_SYNC (856..975), else ~H_POL.
  - vsync = V_POL when V_DISP+V_FP ≤ y < V_DISP+V_FP+V_SYNC (637..642), else ~V_POL.
  - video_on = (x < H_DISP) && (y < V_DISP).
- Pulse outputs:
  - line_end is high for exactly the one clk whose p_tick wraps x.
  - frame_start is high for exactly the one clk whose p_tick wraps both x and y. frame_start always coincides with a line_end.
- Reset mid-frame: on the next clk, all state returns to reset values with no partial sync pulse extended. Timing restarts from (0,0).
- Outputs are held stable between ticks. No combinational path from any input to any output.

Decomposition:
- Package svga_timing_pkg holds:
  - 800x600@72 constants: listed defaults, CLK_DIV 2.
  - 640x480@60 constants: 640/16/96/48, 480/10/2/33, polarities 0, CLK_DIV 4.
  - Derived H_TOTAL/V_TOTAL functions.
  - Counter width constants (11, 10).
- One sub-module: pixel_tick_gen (the divider: clk, reset → p_tick). The counters and sync decode stay in svga_sync_gen.

Test Plan:
- Reset held 10 clks, then released → p_tick first high on clk 2 after release, then every 2 clks; hsync = vsync = 1'b0 and video_on = 0 during reset.
- Run one line (2080 clks) → pixel_x sequence 0..1039 then 0:
  - hsync high exactly for x = 856..975 (120 ticks = 240 clks);
  - video_on high for x = 0..799 on y = 0;
  - line_end single pulse at the 1039→0 wrap.
- Run one full frame (1,385,280 clks) → vsync high exactly for y = 637..642; frame_start pulses once, at the 665/1039 → 0/0 wrap; video_on never high for y ≥ 600.
- Assert reset for 1 clk at x = 900, y = 640 (inside both syncs) → next clk: hsync = vsync = 0, counters = 0, no pulse outputs; first tick after release gives x = 1.
- Re-parameterise with the 640x480@60 package constants → line of 800 ticks (3200 clks), frame of 525 lines, hsync low for x = 656..751, vsync low for y = 490..491.
- Over 3 consecutive frames, count ticks between frame_start pulses → exactly 692,640 each; line_end count per frame is 666.
